bp_reg_file: RTL and testbench
==============================

// Module: bp_reg_file
// PURPOSE
//  BytePipe register file for host register access over USB, sitting beside the USB/BytePipe bridge.
//  Extends the 1B-location BytePipe register memory with:
//    reset values, read-only hardware status locations, per-register write strobes, counted read/write bursts.
//  Exposes register contents to surrounding logic as a flat vector.
// PARAMETERS
//  N_REG        63          in {1..127}; implemented locations 1..N_REG.
//  VALUE0       8'h00       value read from location 0 (magic/ID).
//  ZERO_UNIMPL  1           1: locations >N_REG read 8'h00; 0: read value don't-care.
//  RO_MASK      128'h0      bit a set -> location a is read-only, sourced from i_hw_data; bit 0 ignored.
//  RESET_VALUES {8*N_REG{0}} flat; byte r holds the reset value of location r+1.
// PORTS
//  i_clk       in   1        clock.
//  i_rst_n     in   1        synchronous reset, active-low.
//  i_cg        in   1        clock-gate enable; 0 freezes all state.
//  i_bp_data   in   8        BytePipe downstream byte.
//  i_bp_valid  in   1        downstream valid.
//  o_bp_ready  out  1        downstream ready.
//  o_bp_data   out  8        BytePipe upstream byte (response).
//  o_bp_valid  out  1        upstream valid.
//  i_bp_ready  in   1        upstream ready.
//  o_reg_data  out  8*N_REG  current register values; byte r is location r+1.
//  i_hw_data   in   8*N_REG  hardware values for RO locations; byte r is location r+1.
//  o_wr_strobe out  N_REG    1-cycle pulse on the cycle location r+1 is written; never for RO locations.
// BEHAVIOUR
//  - Command byte: bit7=1 write, 0 read; bits[6:0]=address. Accepted = i_bp_valid && o_bp_ready.
//  - o_bp_ready = i_cg && state!=RBURST && (!o_bp_valid || i_bp_ready).
//  - Reset (i_rst_n=0 at edge): state=IDLE, o_bp_valid=0, o_bp_data=0, burst=0, addr=0.
//    Registers take RESET_VALUES; o_wr_strobe=0. Pending response is dropped.
//  - FSM IDLE: read cmd -> load addr, response 1 cycle later.
//    If burst!=0 -> RBURST, else stay IDLE.
//  - FSM IDLE: write cmd -> load addr -> WDATA.
//  - FSM WDATA: each accepted data byte stores (if writable), pulses strobe, and queues the previous value as response.
//    After the last beat -> IDLE.
//  - FSM RBURST: emits one response per upstream acceptance.
//    After the final beat -> IDLE; no downstream bytes consumed meanwhile.
//  - Beats per transaction = burst_q+1. burst_q is cleared when the transaction ends.
//    Write to location 0 loads burst_q with the data byte. Response is VALUE0; transaction is always single-beat.
//  - Read value mux: loc 0 -> VALUE0; RO -> i_hw_data sampled on the response-load cycle.
//    loc >N_REG -> 0 (ZERO_UNIMPL=1). Else stored value.
//  - Writes to RO or >N_REG locations are dropped: no store, no strobe, response still returned.
//  - Response register o_bp_data/o_bp_valid holds stable until i_bp_ready; latency 1 cycle from acceptance.
//  - Burst address is fixed unless BP_REG_FILE_AUTOINC_EN (see below).
//  - A burst load arriving mid-transaction is impossible: loc 0 is only written via its own command.
// CONFIGURATION
//  BP_REG_FILE_AUTOINC_EN defined:
//   - Address increments after every burst beat; N_REG wraps to 1 (never 0).
//   - A start address >N_REG increments to the next location, wrapping >127 to 1.
//  Undefined:
//   - All beats target the command address (polling/FIFO-style access).
// TESTING
//  1. Reset, read loc 5 (cmd 0x05) -> resp = RESET_VALUES byte 4; read loc 0 -> VALUE0.
//  2. Write 0x85,0xA5 -> resp old value, o_wr_strobe[4] pulses 1 cycle, o_reg_data byte4=0xA5.
//     Read 0x05 -> 0xA5.
//  3. RO_MASK bit3 set, i_hw_data byte2=0x3C: write 0x83,0xFF -> resp 0x3C, no strobe.
//     Read 0x03 -> 0x3C.
//  4. Write 0x80,0x02, then read 0x07 -> 3 responses without further input.
//     Hold i_bp_ready=0 for 4 cycles mid-burst -> o_bp_data stable, o_bp_ready=0.
//  5. N_REG=63: read 0x7F -> 0x00; write 0xFF,0x11 -> resp 0x00, no strobe.
//     AUTOINC burst 3 from 0x3F -> addresses 63,1,2,3.
//  6. Assert i_rst_n=0 during RBURST with o_bp_valid=1 -> next cycle o_bp_valid=0, IDLE, registers at reset values.

Source files
------------

// File: rtl/bp_reg_file.sv
// BytePipe register file: command/data byte protocol over BytePipe with reset values,
// read-only hardware locations, write strobes and counted bursts. BP_REG_FILE_AUTOINC_EN enables burst address increment.
module bp_reg_file #(
  parameter int                 N_REG        = 63,
  parameter logic [7:0]         VALUE0       = 8'h00,
  parameter bit                 ZERO_UNIMPL  = 1'b1,
  parameter logic [127:0]       RO_MASK      = 128'h0,
  parameter logic [8*N_REG-1:0] RESET_VALUES = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cg,
  input  logic [7:0]         i_bp_data,
  input  logic               i_bp_valid,
  output logic               o_bp_ready,
  output logic [7:0]         o_bp_data,
  output logic               o_bp_valid,
  input  logic               i_bp_ready,
  output logic [8*N_REG-1:0] o_reg_data,
  input  logic [8*N_REG-1:0] i_hw_data,
  output logic [N_REG-1:0]   o_wr_strobe
);

  typedef enum logic [1:0] {IDLE, WDATA, RBURST} stateT;

  stateT       state, stateNext;
  logic [6:0]  addrQ;
  logic [7:0]  burstQ;
  logic [7:0]  regMem [N_REG];
  logic [6:0]  rdAddr;
  logic [7:0]  rdValue;
  logic [6:0]  beatAddr;
  logic        dnAccept;
  logic        upAccept;
  logic        loadResp;
  logic        wrBeat;

`ifdef BP_REG_FILE_AUTOINC_EN
  // Wrap back to location 1 so a burst never lands on the magic/ID location.
  function automatic logic [6:0] stepAddr(input logic [6:0] a);
    return (a == 7'(N_REG) || a == 7'd127) ? 7'd1 : a + 7'd1;
  endfunction
`else
  function automatic logic [6:0] stepAddr(input logic [6:0] a);
    return a;
  endfunction
`endif

  assign o_bp_ready = i_cg && (state != RBURST) && (!o_bp_valid || i_bp_ready);
  assign dnAccept   = i_bp_valid && o_bp_ready;
  assign upAccept   = i_cg && o_bp_valid && i_bp_ready;
  assign beatAddr   = stepAddr(addrQ);

  for (genvar r = 0; r < N_REG; r++) begin : gRegOut
    assign o_reg_data[8*r +: 8] = RO_MASK[r+1] ? i_hw_data[8*r +: 8] : regMem[r];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else if (i_cg) begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    rdAddr    = addrQ;
    loadResp  = 1'b0;
    wrBeat    = 1'b0;
    case (state)
      IDLE: begin
        rdAddr = i_bp_data[6:0];
        if (dnAccept) begin
          if (i_bp_data[7]) begin
            stateNext = WDATA;
          end else begin
            loadResp = 1'b1;
            if (burstQ != 8'd0) stateNext = RBURST;
          end
        end
      end
      WDATA: begin
        if (dnAccept) begin
          wrBeat   = 1'b1;
          loadResp = 1'b1;
          if (addrQ == 7'd0 || burstQ == 8'd0) stateNext = IDLE;
        end
      end
      RBURST: begin
        rdAddr = beatAddr;
        if (upAccept) begin
          loadResp = 1'b1;
          if (burstQ == 8'd1) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Read mux also supplies the "previous value" returned for every write beat.
  always_comb begin
    rdValue = ZERO_UNIMPL ? 8'h00 : 8'hxx;
    if (rdAddr == 7'd0) rdValue = VALUE0;
    for (int r = 0; r < N_REG; r++) begin
      if (rdAddr == 7'(r + 1)) begin
        rdValue = RO_MASK[r+1] ? i_hw_data[8*r +: 8] : regMem[r];
      end
    end
  end

  // burstQ doubles as the remaining-beat count, so it reaches zero as the transaction ends.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addrQ       <= '0;
      burstQ      <= '0;
      o_bp_valid  <= 1'b0;
      o_bp_data   <= '0;
      o_wr_strobe <= '0;
      for (int r = 0; r < N_REG; r++) regMem[r] <= RESET_VALUES[8*r +: 8];
    end else if (i_cg) begin
      o_wr_strobe <= '0;
      if (loadResp) begin
        o_bp_data  <= rdValue;
        o_bp_valid <= 1'b1;
      end else if (i_bp_ready) begin
        o_bp_valid <= 1'b0;
      end
      case (state)
        IDLE: if (dnAccept) addrQ <= i_bp_data[6:0];
        WDATA: begin
          if (wrBeat) begin
            if (addrQ == 7'd0) begin
              burstQ <= i_bp_data;
            end else begin
              for (int r = 0; r < N_REG; r++) begin
                if (addrQ == 7'(r + 1) && !RO_MASK[r+1]) begin
                  regMem[r]      <= i_bp_data;
                  o_wr_strobe[r] <= 1'b1;
                end
              end
              if (burstQ != 8'd0) burstQ <= burstQ - 8'd1;
              addrQ <= beatAddr;
            end
          end
        end
        RBURST: begin
          if (upAccept) begin
            burstQ <= burstQ - 8'd1;
            addrQ  <= beatAddr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_reg_file.sv
// Self-checking bench for bp_reg_file: directed literal scenarios, then randomized traffic
// compared every cycle against a transaction-level model of the register file.
module tb_bp_reg_file;

  localparam int NREG = 63;
  localparam logic [7:0] MAGIC = 8'hA7;
  localparam logic [127:0] ROM = (128'h1 << 3) | (128'h1 << 10);

  function automatic logic [7:0] rvByte(input int r);
    return 8'(r * 13 + 5);
  endfunction

  function automatic logic [8*NREG-1:0] makeRv();
    logic [8*NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[8*r +: 8] = rvByte(r);
    return v;
  endfunction

  localparam logic [8*NREG-1:0] RV = makeRv();

  logic clk = 1'b0;
  logic rstN, cg, bpValid, bpReady;
  logic [7:0] bpData;
  logic [8*NREG-1:0] hwData;
  logic bpReadyOut, bpValidOut;
  logic [7:0] bpDataOut;
  logic [8*NREG-1:0] regData;
  logic [NREG-1:0] wrStrobe;

  int checks = 0;
  int errors = 0;

  bp_reg_file #(
    .N_REG(NREG), .VALUE0(MAGIC), .ZERO_UNIMPL(1'b1), .RO_MASK(ROM), .RESET_VALUES(RV)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_cg(cg),
    .i_bp_data(bpData), .i_bp_valid(bpValid), .o_bp_ready(bpReadyOut),
    .o_bp_data(bpDataOut), .o_bp_valid(bpValidOut), .i_bp_ready(bpReady),
    .o_reg_data(regData), .i_hw_data(hwData), .o_wr_strobe(wrStrobe)
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_WDATA, M_RBURST} modeT;
  modeT mMode;
  logic [7:0] mem [128];
  logic [7:0] mBurst;
  int mLeft;
  int mAddr;
  bit expValid;
  logic [7:0] expData;
  logic [NREG-1:0] expStrobe;
  bit modelValid = 0;

  function automatic bit isRo(input int a);
    return a >= 1 && a <= NREG && ROM[a];
  endfunction

  function automatic logic [7:0] readVal(input int a);
    if (a == 0) return MAGIC;
    if (a > NREG) return 8'h00;
    if (isRo(a)) return hwData[8*(a-1) +: 8];
    return mem[a];
  endfunction

  function automatic int nextAddr(input int a);
`ifdef BP_REG_FILE_AUTOINC_EN
    return (a == NREG || a == 127) ? 1 : a + 1;
`else
    return a;
`endif
  endfunction

  task automatic modelReset();
    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
    for (int r = 0; r < NREG; r++) mem[r+1] = rvByte(r);
    mMode = M_IDLE; mBurst = 0; mLeft = 0; mAddr = 0;
    expValid = 0; expData = 8'h00; expStrobe = '0;
  endtask

  task automatic modelStep();
    bit dnAcc, upAcc, push;
    logic [7:0] pv;
    dnAcc = bpValid && (mMode != M_RBURST) && (!expValid || bpReady);
    upAcc = expValid && bpReady;
    push = 0; pv = 8'h00;
    expStrobe = '0;
    case (mMode)
      M_IDLE: if (dnAcc) begin
        mAddr = int'(bpData[6:0]);
        if (bpData[7]) begin
          mMode = M_WDATA; mLeft = int'(mBurst);
        end else begin
          push = 1; pv = readVal(mAddr);
          if (mBurst != 0) begin mMode = M_RBURST; mLeft = int'(mBurst); end
        end
      end
      M_WDATA: if (dnAcc) begin
        push = 1; pv = readVal(mAddr);
        if (mAddr == 0) begin
          mBurst = bpData; mMode = M_IDLE;
        end else begin
          if (mAddr <= NREG && !isRo(mAddr)) begin
            mem[mAddr] = bpData; expStrobe[mAddr-1] = 1'b1;
          end
          if (mLeft == 0) begin mMode = M_IDLE; mBurst = 0; end
          else mLeft--;
          mAddr = nextAddr(mAddr);
        end
      end
      M_RBURST: if (upAcc) begin
        mAddr = nextAddr(mAddr);
        push = 1; pv = readVal(mAddr);
        mLeft--;
        if (mLeft == 0) begin mMode = M_IDLE; mBurst = 0; end
      end
      default: ;
    endcase
    if (push) begin expValid = 1; expData = pv; end
    else if (bpReady) expValid = 0;
  endtask

  always @(posedge clk) begin
    if (!rstN) begin modelReset(); modelValid = 1; end
    else if (modelValid && cg) modelStep();
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (modelValid && rstN) begin
      logic [8*NREG-1:0] expReg, mask;
      for (int r = 0; r < NREG; r++) begin
        expReg[8*r +: 8] = mem[r+1];
        mask[8*r +: 8] = isRo(r+1) ? 8'h00 : 8'hFF;
      end
      checkOutput("bpReady", 64'(bpReadyOut), 64'(cg && mMode != M_RBURST && (!expValid || bpReady)));
      checkOutput("bpValid", 64'(bpValidOut), 64'(expValid));
      if (expValid) checkOutput("bpData", 64'(bpDataOut), 64'(expData));
      checkOutput("wrStrobe", 64'(wrStrobe), 64'(expStrobe));
      checks++;
      if ((regData & mask) !== (expReg & mask)) begin
        errors++;
        $display("[TB] FAIL regData: got %h expected %h", regData & mask, expReg & mask);
      end
    end
  end

  // ---------------- response capture for directed checks ----------------
  logic [7:0] gotResp [$];
  bit capture = 0;
  always @(negedge clk) begin
    if (capture && rstN && cg && bpValidOut && bpReady) gotResp.push_back(bpDataOut);
  end

  task automatic sendByte(input logic [7:0] b);
    bit done = 0;
    bpData = b; bpValid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); done = bpReadyOut;
      @(posedge clk); #1;
    end
    bpValid = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("[TB] FAIL sendTimeout: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic waitResp(input int n);
    for (int i = 0; i < 60 && gotResp.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expectResp(input string name, input logic [7:0] exp);
    waitResp(1);
    if (gotResp.size() == 0) begin
      checkOutput({name, "_timeout"}, 64'h0, 64'h1);
    end else begin
      checkOutput(name, 64'(gotResp.pop_front()), 64'(exp));
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      rstN = ($urandom_range(0, 299) != 0);
      cg = ($urandom_range(0, 9) != 0);
      bpReady = ($urandom_range(0, 3) != 0);
      bpValid = ($urandom_range(0, 2) != 0);
      if (mMode == M_WDATA && mAddr == 0) bpData = 8'($urandom_range(0, 5));
      else if ($urandom_range(0, 7) == 0) bpData = 8'h80;
      else bpData = 8'($urandom);
      for (int r = 0; r < NREG; r++) hwData[8*r +: 8] = 8'($urandom);
    end
  endtask

  logic [7:0] b2, b3, bA, bB, bC, bD;

  initial begin
    rstN = 1'b0; cg = 1'b1; bpValid = 1'b0; bpReady = 1'b1; bpData = 8'h00;
    for (int r = 0; r < NREG; r++) hwData[8*r +: 8] = 8'($urandom);
    hwData[8*2 +: 8] = 8'h3C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetValid", 64'(bpValidOut), 64'h0);
    checkOutput("resetData", 64'(bpDataOut), 64'h0);
    checkOutput("resetStrobe", 64'(wrStrobe), 64'h0);
    checkOutput("resetReg5", 64'(regData[39:32]), 64'h39);
    @(posedge clk); #1;
    rstN = 1'b1;
    capture = 1;

    sendByte(8'h05); expectResp("readLoc5", 8'h39);
    sendByte(8'h00); expectResp("readLoc0", 8'hA7);

    sendByte(8'h85); sendByte(8'hA5);
    checkOutput("strobe4", 64'(wrStrobe), 64'h10);
    @(posedge clk); #1;
    checkOutput("strobeOnePulse", 64'(wrStrobe), 64'h0);
    expectResp("writeOld5", 8'h39);
    checkOutput("reg5New", 64'(regData[39:32]), 64'hA5);
    sendByte(8'h05); expectResp("readBack5", 8'hA5);

    sendByte(8'h83); sendByte(8'hFF);
    checkOutput("roNoStrobe", 64'(wrStrobe), 64'h0);
    expectResp("writeRoResp", 8'h3C);
    sendByte(8'h03); expectResp("readRo3", 8'h3C);

`ifdef BP_REG_FILE_AUTOINC_EN
    b2 = 8'h60; b3 = 8'h6D; bA = 8'h05; bB = 8'h12; bC = 8'h3C;
`else
    b2 = 8'h53; b3 = 8'h53; bA = 8'h2B; bB = 8'h2B; bC = 8'h2B;
`endif
    bD = 8'h2B;
    sendByte(8'h80); sendByte(8'h02); expectResp("burstLoad", 8'hA7);
    sendByte(8'h07);
    waitResp(1);
    bpReady = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("holdReady", 64'(bpReadyOut), 64'h0);
      checkOutput("holdValid", 64'(bpValidOut), 64'h1);
      checkOutput("holdData", 64'(bpDataOut), 64'(b2));
    end
    @(posedge clk); #1;
    bpReady = 1'b1;
    waitResp(3);
    expectResp("burstBeat1", 8'h53);
    expectResp("burstBeat2", b2);
    expectResp("burstBeat3", b3);

    sendByte(8'h7F); expectResp("readUnimpl", 8'h00);
    sendByte(8'hFF); sendByte(8'h11);
    checkOutput("unimplNoStrobe", 64'(wrStrobe), 64'h0);
    expectResp("writeUnimpl", 8'h00);
    sendByte(8'h80); sendByte(8'h03); expectResp("burst3Load", 8'hA7);
    sendByte(8'h3F);
    waitResp(4);
    expectResp("wrapBeat1", bD);
    expectResp("wrapBeat2", bA);
    expectResp("wrapBeat3", bB);
    expectResp("wrapBeat4", bC);

    sendByte(8'h80); sendByte(8'h05); expectResp("burst5Load", 8'hA7);
    sendByte(8'h01);
    waitResp(1);
    bpReady = 1'b0;
    @(negedge clk);
    checkOutput("preResetValid", 64'(bpValidOut), 64'h1);
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midResetValid", 64'(bpValidOut), 64'h0);
    checkOutput("midResetReady", 64'(bpReadyOut), 64'h1);
    checkOutput("midResetReg5", 64'(regData[39:32]), 64'h39);
    @(posedge clk); #1;
    rstN = 1'b1; bpReady = 1'b1;
    capture = 0;
    gotResp.delete();

    applyStimulus(4000);
    @(posedge clk); #1;
    bpValid = 1'b0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
